// File: rtl/regs_bank.sv
// Multi-channel register bank: per-channel DATA/SHADOW/CTRL/STAT registers behind a
// single-cycle request/response bus, with global snapshot and a level interrupt.
module regs_bank #(
    parameter int              DW       = 32,
    parameter int              AW       = 10,
    parameter int              NCH      = 4,
    parameter logic [DW-1:0]   DATA_RST = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            snap,
    output logic            rsp_valid,
    output logic [DW-1:0]   rdata,
    output logic            err,
    output logic            irq
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = DW / 8;
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LIMIT = LW'(NCH * 16);

    logic [DW-1:0]  data_q   [NCH];
    logic [DW-1:0]  shadow_q [NCH];
    logic [NCH-1:0] ctrl_auto;
    logic [NCH-1:0] ctrl_ie;
    logic [NCH-1:0] stat_wr;
    logic [NCH-1:0] stat_ovf;

    logic [CW-1:0]  ch_idx;
    logic [1:0]     reg_sel;
    logic           in_range;
    logic           mapped;
    logic           wr_data;
    logic           wr_ctrl;
    logic           wr_stat;
    logic [DW-1:0]  rd_val;

    generate
        if (AW >= CW + 4) begin : g_idx
            assign ch_idx = addr[CW+3:4];
        end else begin : g_idx_one
            assign ch_idx = '0;
        end
    endgenerate

    assign reg_sel  = addr[3:2];
    assign in_range = ({1'b0, addr} < LIMIT);
    // SHADOW is read-only, so a write to it is decoded as unmapped.
    assign mapped   = in_range && (addr[1:0] == 2'b00) && !(we && (reg_sel == 2'd1));
    assign wr_data  = req && we && mapped && (reg_sel == 2'd0);
    assign wr_ctrl  = req && we && mapped && (reg_sel == 2'd2);
    assign wr_stat  = req && we && mapped && (reg_sel == 2'd3);

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            2'd0:    rd_val = data_q[ch_idx];
            2'd1:    rd_val = shadow_q[ch_idx];
            2'd2:    rd_val[1:0] = {ctrl_ie[ch_idx], ctrl_auto[ch_idx]};
            default: rd_val[1:0] = {stat_ovf[ch_idx], stat_wr[ch_idx]};
        endcase
    end

    // Shadow loads read the pre-edge DATA, so a same-cycle write is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                data_q[i]   <= DATA_RST;
                shadow_q[i] <= DATA_RST;
            end
            ctrl_auto <= '0;
            ctrl_ie   <= '0;
            stat_wr   <= '0;
            stat_ovf  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ctrl_auto[i] || snap) begin
                    shadow_q[i] <= data_q[i];
                end
                if (wr_data && (ch_idx == CW'(i))) begin
                    for (int b = 0; b < SW; b++) begin
                        if (wstrb[b]) begin
                            data_q[i][b*8 +: 8] <= wdata[b*8 +: 8];
                        end
                    end
                    stat_wr[i] <= 1'b1;
                    if (stat_wr[i]) begin
                        stat_ovf[i] <= 1'b1;
                    end
                end
                if (wr_ctrl && (ch_idx == CW'(i))) begin
                    ctrl_auto[i] <= wdata[0];
                    ctrl_ie[i]   <= wdata[1];
                end
                if (wr_stat && (ch_idx == CW'(i))) begin
                    if (wdata[0]) begin
                        stat_wr[i] <= 1'b0;
                    end
                    if (wdata[1]) begin
                        stat_ovf[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Bus: a request is taken on any edge where req=1 (no backpressure); its
    // response appears as a one-cycle rsp_valid pulse with rdata/err on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            irq       <= 1'b0;
        end else begin
            rsp_valid <= req;
            err       <= req && !mapped;
            rdata     <= (req && !we && mapped) ? rd_val : '0;
            irq       <= |(ctrl_ie & stat_wr);
        end
    end

endmodule
